// File: rtl/audio_mix_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the audio mixer.
package audio_mix_pkg;

  localparam int SMP_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } mix_state_e;

  typedef struct packed {
    logic [SMP_W-1:0] val;
    logic             clipped;
  } sat_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Clamp a sign-extended sum into the signed 16-bit range.
  function automatic sat_t sat16(input logic signed [31:0] x);
    sat_t r;
    if (x > 32'sd32767) begin
      r.val     = 16'h7FFF;
      r.clipped = 1'b1;
    end else if (x < -32'sd32768) begin
      r.val     = 16'h8000;
      r.clipped = 1'b1;
    end else begin
      r.val     = x[SMP_W-1:0];
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_dsm1.sv
// First-order delta-sigma modulator: offset-binary phase accumulator whose carry is the bitstream.
module audio_dsm1
  import audio_mix_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [SMP_W-1:0] din,
  output logic                    dout
);

  logic [SMP_W-1:0] dacc_q, dacc_d;
  logic             dout_q, dout_d;
  logic [SMP_W-1:0] u;
  logic [SMP_W:0]   sum;

  always_comb begin
    u      = din ^ 16'h8000;
    sum    = {1'b0, dacc_q} + {1'b0, u};
    dacc_d = sum[SMP_W-1:0];
    dout_d = sum[SMP_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dacc_q <= '0;
      dout_q <= 1'b0;
    end else begin
      dacc_q <= dacc_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/audio_mix_dac.sv
// Time-multiplexed NCH-channel mixer with 16-bit saturation feeding a 1-bit delta-sigma output.
module audio_mix_dac
  import audio_mix_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SMP_W*NCH-1:0]   ch_in,
  input  logic [NCH-1:0]         ch_en,
  input  logic                   smp_stb,
  output logic [SMP_W-1:0]       mix_out,
  output logic                   mix_valid,
  output logic                   busy,
  output logic                   clip,
  output logic                   overrun,
  output logic                   dac_out
);

  localparam int AW = SMP_W + clog2(NCH);
  localparam int IW = clog2(NCH);

  mix_state_e           state_q, state_d;
  logic [SMP_W*NCH-1:0] snap_q, snap_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [SMP_W-1:0]     mix_q, mix_d;
  logic                 valid_q, valid_d;
  logic                 clip_q, clip_d;
  logic                 overrun_q, overrun_d;
  logic [SMP_W-1:0]     sel;
  sat_t                 sat;

  // mix_valid/clip are single-cycle pulses with no backpressure; mix_out holds until the next pulse.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    mix_d     = mix_q;
    valid_d   = 1'b0;
    clip_d    = 1'b0;
    overrun_d = overrun_q | (smp_stb && (state_q != IDLE));
    sel       = snap_q[idx_q*SMP_W +: SMP_W];
    sat       = sat16({{(32-AW){acc_q[AW-1]}}, acc_q});
    case (state_q)
      IDLE: begin
        if (smp_stb) begin
          for (int k = 0; k < NCH; k++) begin
            snap_d[k*SMP_W +: SMP_W] = ch_en[k] ? ch_in[k*SMP_W +: SMP_W] : '0;
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + {{(AW-SMP_W){sel[SMP_W-1]}}, sel};
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NCH-1)) state_d = SAT;
      end
      SAT: begin
        mix_d   = sat.val;
        clip_d  = sat.clipped;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      mix_q     <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      mix_q     <= mix_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  assign mix_out   = mix_q;
  assign mix_valid = valid_q;
  assign clip      = clip_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

  audio_dsm1 u_dsm (
    .clk   (clk),
    .reset (reset),
    .din   (mix_q),
    .dout  (dac_out)
  );

endmodule

// File: tb/tb_audio_mix_dac.sv
// Scoreboard bench for audio_mix_dac: arithmetic reference model plus ones-density checks on the bitstream.
module tb_audio_mix_dac;

  localparam int NCH = 4;
  localparam int LAT = NCH + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [16*NCH-1:0] ch_in;
  logic [NCH-1:0]    ch_en;
  logic              smp_stb;
  logic [15:0]       mix_out;
  logic              mix_valid, busy, clip, overrun, dac_out;

  audio_mix_dac #(.NCH(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_in     (ch_in),
    .ch_en     (ch_en),
    .smp_stb   (smp_stb),
    .mix_out   (mix_out),
    .mix_valid (mix_valid),
    .busy      (busy),
    .clip      (clip),
    .overrun   (overrun),
    .dac_out   (dac_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [16:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer sum of enabled signed samples, then clamp.
  function automatic logic [16:0] model_mix(input logic [16*NCH-1:0] d, input logic [NCH-1:0] en);
    int s;
    s = 0;
    for (int k = 0; k < NCH; k++)
      if (en[k]) s += int'($signed(d[16*k +: 16]));
    if (s > 32767)  return {16'h7FFF, 1'b1};
    if (s < -32768) return {16'h8000, 1'b1};
    return {s[15:0], 1'b0};
  endfunction

  function automatic logic [16*NCH-1:0] rand_data();
    logic [16*NCH-1:0] d;
    for (int k = 0; k < NCH; k++) begin
      case ($urandom_range(0, 3))
        0:       d[16*k +: 16] = 16'h7FFF;
        1:       d[16*k +: 16] = 16'h8000;
        default: d[16*k +: 16] = 16'($urandom);
      endcase
    end
    return d;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [16:0] e;
    int          c;
    if (mix_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: mix_out=0x%0h with nothing expected", mix_out);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("mix_out", 32'(mix_out), 32'(e[16:1]));
        check("clip", 32'(clip), 32'(e[0]));
        check("latency", cyc, c);
      end
    end else if (clip) begin
      n_tests++;
      n_fail++;
      $display("FAIL clip_without_valid: clip=1, required 0");
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe occupies two negedges; inputs are scrambled right after to prove the snapshot.
  task automatic do_strobe(input logic [16*NCH-1:0] d, input logic [NCH-1:0] en, input bit accept);
    @(negedge clk);
    ch_in   = d;
    ch_en   = en;
    smp_stb = 1'b1;
    if (accept) begin
      exp_q.push_back(model_mix(d, en));
      exp_cyc_q.push_back(cyc + LAT);
    end
    @(negedge clk);
    smp_stb = 1'b0;
    ch_in   = {$urandom, $urandom};
    ch_en   = NCH'($urandom);
    if (accept) check("busy_after_strobe", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset   = 1'b1;
    smp_stb = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic count_ones(input int n, output int ones, output int same_pairs);
    logic prev;
    ones       = 0;
    same_pairs = 0;
    prev       = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dac_out) ones++;
      if (i > 0 && dac_out == prev) same_pairs++;
      prev = dac_out;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [16*NCH-1:0] d;
    logic [16:0]       e;
    logic [15:0]       u;
    int                ones, sp, lo;

    reset   = 1'b1;
    smp_stb = 1'b0;
    ch_in   = '0;
    ch_en   = '0;
    idle(3);
    check("rst_mix_out", 32'(mix_out), 32'd0);
    check("rst_mix_valid", 32'(mix_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clip", 32'(clip), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_dac_out", 32'(dac_out), 32'd0);
    reset = 1'b0;

    // Mid-scale input: strictly alternating bitstream.
    idle(2);
    count_ones(1024, ones, sp);
    check("dsm_zero_ones", ones, 512);
    check("dsm_zero_alternates", sp, 0);

    do_strobe({16'h0010, 16'hF000, 16'h0800, 16'h1000}, 4'hF, 1'b1);
    drain();
    check("mix_0810_value", 32'(mix_out), 32'h0810);
    do_strobe({4{16'h7FFF}}, 4'hF, 1'b1);
    drain();
    do_strobe({4{16'h8000}}, 4'hF, 1'b1);
    drain();
    do_strobe({4{16'h0100}}, 4'b0101, 1'b1);
    drain();
    check("mix_masked_value", 32'(mix_out), 32'h0200);

    do_strobe({16'h0, 16'h0, 16'h0, 16'h4000}, 4'hF, 1'b1);
    drain();
    idle(2);
    count_ones(1024, ones, sp);
    check("dsm_4000_ones", ones, 768);

    // Strobe spacing: 6 accepted, 5 overruns.
    do_strobe({$urandom, $urandom}, 4'hF, 1'b1);
    idle(4);
    do_strobe({$urandom, $urandom}, 4'hF, 1'b1);
    drain();
    check("no_overrun_spacing6", 32'(overrun), 32'd0);
    do_strobe({$urandom, $urandom}, 4'hF, 1'b1);
    idle(3);
    do_strobe({$urandom, $urandom}, 4'hF, 1'b0);
    drain();
    check("overrun_spacing5", 32'(overrun), 32'd1);

    apply_reset();
    check("overrun_cleared", 32'(overrun), 32'd0);
    do_strobe({$urandom, $urandom}, 4'hF, 1'b1);
    idle(1);
    do_strobe({$urandom, $urandom}, 4'hF, 1'b0);
    drain();
    check("overrun_spacing3", 32'(overrun), 32'd1);
    idle(20);
    check("overrun_sticky", 32'(overrun), 32'd1);
    do_strobe({$urandom, $urandom}, NCH'($urandom), 1'b1);
    drain();

    // Abort a mix with reset in cycle 3.
    do_strobe({4{16'h0100}}, 4'hF, 1'b1);
    drain();
    check("pre_abort_mix", 32'(mix_out), 32'h0400);
    do_strobe({$urandom, $urandom}, 4'hF, 1'b0);
    idle(1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(mix_valid), 32'd0);
    check("abort_mix_out", 32'(mix_out), 32'd0);
    check("abort_dac_out", 32'(dac_out), 32'd0);
    reset = 1'b0;
    idle(10);
    do_strobe({$urandom, $urandom}, 4'hF, 1'b1);
    drain();

    for (int i = 0; i < 24; i++) begin
      do_strobe(rand_data(), NCH'($urandom), 1'b1);
      idle($urandom_range(4, 8));
    end
    drain();
    check("overrun_random_spacing", 32'(overrun), 32'd0);

    // Random levels: ones over 1024 clocks must match floor/ceil of 1024*u/65536.
    for (int j = 0; j < 3; j++) begin
      d = rand_data();
      e = model_mix(d, 4'hF);
      do_strobe(d, 4'hF, 1'b1);
      drain();
      idle(2);
      u  = e[16:1] ^ 16'h8000;
      lo = (1024 * int'(u)) / 65536;
      count_ones(1024, ones, sp);
      check("dsm_random_density", 32'(ones >= lo && ones <= lo + 1), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
